fetch_sequencer: RTL and testbench

Control FSM for the instruction fetch datapath. It owns the fetch address, steps the program counter, MAR, program memory, MDR and IR load strobes in order, and presents each fetched instruction to decode under a valid/ready handshake. It also handles branch redirects and halt requests. It sits beside the fetch datapath and replaces the externally driven `*_rd_wr` pins.

---
 rtl/fetch_seq_pkg.sv | 28 ++
 rtl/fetch_sequencer.sv | 111 +++++++++++
 tb/tb_fetch_sequencer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PC_LD  = 3'd1,
    ST_MAR_LD = 3'd2,
    ST_PM_RD  = 3'd3,
    ST_MDR_LD = 3'd4,
    ST_IR_LD  = 3'd5,
    ST_VALID  = 3'd6
  } fetch_state_t;

  localparam int                     FETCH_CNT_W    = 8;
  localparam logic [FETCH_CNT_W-1:0] FETCH_CNT_MAX  = 8'd255;
  localparam int                     PM_LAT_DEFAULT = 1;

  // One bit per datapath load strobe plus the decode-side valid.
  typedef struct packed {
    logic pc;
    logic mar;
    logic pm;
    logic mdr;
    logic ir;
    logic vld;
  } strobe_t;

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch control FSM: steps PC/MAR/PM/MDR/IR strobes and hands each instruction to decode.
// Latency: start to PC load 1 cycle; one instruction per 5+PM_LAT cycles with fetch_ready held.
// Backpressure: holds in VALID with all strobes low until fetch_ready; redirect abandons the fetch.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int PM_LAT = PM_LAT_DEFAULT,
  parameter int ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   halt,
  input  logic                   redirect_valid,
  input  logic [ADDR_W-1:0]      redirect_addr,
  input  logic                   fetch_ready,
  output logic                   fetch_valid,
  output logic [ADDR_W-1:0]      pc_addr,
  output logic                   PC_rd_wr,
  output logic                   MAR_rd_wr,
  output logic                   PM_rd_wr,
  output logic                   MDR_rd_wr,
  output logic                   IR_rd_wr,
  output logic                   busy,
  output logic [FETCH_CNT_W-1:0] fetch_count
);

  localparam int WAIT_W = 2;

  fetch_state_t      state, next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              halt_pend;
  logic              wait_done;
  logic              handshake;
  strobe_t           strb_nxt;

  assign wait_done = (wait_cnt == WAIT_W'(PM_LAT - 1));
  assign handshake = (state == ST_VALID) && fetch_ready;

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (start && !halt && !redirect_valid) next_state = ST_PC_LD;
      ST_PC_LD:  next_state = ST_MAR_LD;
      ST_MAR_LD: next_state = ST_PM_RD;
      ST_PM_RD:  if (wait_done) next_state = ST_MDR_LD;
      ST_MDR_LD: next_state = ST_IR_LD;
      ST_IR_LD:  next_state = ST_VALID;
      ST_VALID:  if (fetch_ready) next_state = (halt_pend || halt) ? ST_IDLE : ST_PC_LD;
      default:   next_state = ST_IDLE;
    endcase
    // Redirect wins over everything outside IDLE, including a pending halt.
    if (state != ST_IDLE && redirect_valid) next_state = ST_PC_LD;
  end

  // Strobes are decoded from the next state so the registered copy lines up with the state.
  always_comb begin
    strb_nxt = '0;
    case (next_state)
      ST_PC_LD:  strb_nxt.pc  = 1'b1;
      ST_MAR_LD: strb_nxt.mar = 1'b1;
      ST_PM_RD:  strb_nxt.pm  = 1'b1;
      ST_MDR_LD: strb_nxt.mdr = 1'b1;
      ST_IR_LD:  strb_nxt.ir  = 1'b1;
      ST_VALID:  strb_nxt.vld = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      halt_pend   <= 1'b0;
      pc_addr     <= '0;
      fetch_count <= '0;
      PC_rd_wr    <= 1'b0;
      MAR_rd_wr   <= 1'b0;
      PM_rd_wr    <= 1'b0;
      MDR_rd_wr   <= 1'b0;
      IR_rd_wr    <= 1'b0;
      fetch_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state    <= next_state;
      wait_cnt <= (state == ST_PM_RD && next_state == ST_PM_RD) ? wait_cnt + 1'b1 : '0;

      if (next_state == ST_IDLE)
        halt_pend <= 1'b0;
      else if (state != ST_IDLE && halt)
        halt_pend <= 1'b1;

      if (redirect_valid)
        pc_addr <= redirect_addr;
      else if (handshake)
        pc_addr <= pc_addr + ADDR_W'(1);

      if (handshake && fetch_count != FETCH_CNT_MAX)
        fetch_count <= fetch_count + 1'b1;

      PC_rd_wr    <= strb_nxt.pc;
      MAR_rd_wr   <= strb_nxt.mar;
      PM_rd_wr    <= strb_nxt.pm;
      MDR_rd_wr   <= strb_nxt.mdr;
      IR_rd_wr    <= strb_nxt.ir;
      fetch_valid <= strb_nxt.vld;
      busy        <= (next_state != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized traffic vs a step-count model.
module tb_fetch_sequencer;

  localparam int L   = 1;
  localparam int AW  = 5;
  localparam int VLD = 5 + L;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          halt = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_addr = '0;
  logic          fetch_ready = 1'b0;
  logic          fetch_valid;
  logic [AW-1:0] pc_addr;
  logic          PC_rd_wr, MAR_rd_wr, PM_rd_wr, MDR_rd_wr, IR_rd_wr;
  logic          busy;
  logic [7:0]    fetch_count;
  logic [6:0]    dut_vec;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: m_step 0 = idle, 1..VLD = position within the current fetch.
  int m_step = 0;
  int m_pc   = 0;
  int m_cnt  = 0;
  bit m_hp   = 1'b0;

  always #5 clk = ~clk;

  fetch_sequencer #(.PM_LAT(L), .ADDR_W(AW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .fetch_ready    (fetch_ready),
    .fetch_valid    (fetch_valid),
    .pc_addr        (pc_addr),
    .PC_rd_wr       (PC_rd_wr),
    .MAR_rd_wr      (MAR_rd_wr),
    .PM_rd_wr       (PM_rd_wr),
    .MDR_rd_wr      (MDR_rd_wr),
    .IR_rd_wr       (IR_rd_wr),
    .busy           (busy),
    .fetch_count    (fetch_count)
  );

  assign dut_vec = {fetch_valid, busy, PC_rd_wr, MAR_rd_wr, PM_rd_wr, MDR_rd_wr, IR_rd_wr};

  function automatic logic [6:0] exp_vec();
    exp_vec = {m_step == VLD, m_step != 0, m_step == 1, m_step == 2,
               (m_step >= 3 && m_step <= 2 + L), m_step == 3 + L, m_step == 4 + L};
  endfunction

  task automatic model_reset();
    m_step = 0; m_pc = 0; m_cnt = 0; m_hp = 1'b0;
  endtask

  task automatic model_step();
    bit hs;
    hs = (m_step == VLD) && fetch_ready;
    if (m_step == 0) begin
      if (redirect_valid) m_pc = int'(redirect_addr);
      else if (start && !halt) m_step = 1;
    end else begin
      if (halt) m_hp = 1'b1;
      if (hs && m_cnt < 255) m_cnt++;
      if (redirect_valid) begin
        m_pc = int'(redirect_addr);
        m_step = 1;
      end else if (hs) begin
        m_pc = (m_pc + 1) % (1 << AW);
        m_step = m_hp ? 0 : 1;
      end else if (m_step < VLD) begin
        m_step++;
      end
      if (m_step == 0) m_hp = 1'b0;
    end
  endtask

  // One clock: the model consumes the same inputs the DUT sampled; returns at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if (dut_vec !== 7'b0) $display("FAIL reset_vec: got %b want 0", dut_vec); else n_pass++;
    n_checks++; if (pc_addr !== '0) $display("FAIL reset_pc: got %0d want 0", pc_addr); else n_pass++;
    n_checks++; if (fetch_count !== 8'd0) $display("FAIL reset_cnt: got %0d want 0", fetch_count); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_stream();
    int n, pc_cyc, last_cyc;
    n = 0; pc_cyc = -1; last_cyc = -1;
    start = 1'b1; fetch_ready = 1'b1;
    for (int cyc = 1; cyc <= 60 && n < 3; cyc++) begin
      tick();
      start = 1'b0;
      n_checks++; if (dut_vec !== exp_vec()) $display("FAIL stream_vec c%0d: got %b want %b", cyc, dut_vec, exp_vec()); else n_pass++;
      if (PC_rd_wr && pc_cyc < 0) begin
        pc_cyc = cyc;
        n_checks++; if (cyc !== 1) $display("FAIL start_to_pc: got %0d want 1", cyc); else n_pass++;
      end
      if (fetch_valid) begin
        if (n == 0) begin
          n_checks++; if (cyc - pc_cyc !== 4 + L) $display("FAIL pc_to_valid: got %0d want %0d", cyc - pc_cyc, 4 + L); else n_pass++;
        end else begin
          n_checks++; if (cyc - last_cyc !== 5 + L) $display("FAIL period: got %0d want %0d", cyc - last_cyc, 5 + L); else n_pass++;
        end
        n_checks++; if (pc_addr !== AW'(n)) $display("FAIL stream_pc: got %0d want %0d", pc_addr, n); else n_pass++;
        n_checks++; if (fetch_count !== 8'(n)) $display("FAIL stream_cnt: got %0d want %0d", fetch_count, n); else n_pass++;
        last_cyc = cyc;
        n++;
        if (n == 3) fetch_ready = 1'b0;
      end
    end
    n_checks++; if (n !== 3) $display("FAIL stream_timeout: got %0d want 3 instructions", n); else n_pass++;
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (dut_vec !== 7'b1100000) $display("FAIL bp_vec: got %b want 1100000", dut_vec); else n_pass++;
      n_checks++; if (pc_addr !== AW'(2)) $display("FAIL bp_pc: got %0d want 2", pc_addr); else n_pass++;
    end
    fetch_ready = 1'b1;
    tick();
    n_checks++; if (pc_addr !== AW'(3)) $display("FAIL bp_pc_after: got %0d want 3", pc_addr); else n_pass++;
    n_checks++; if (fetch_count !== 8'd3) $display("FAIL bp_cnt_after: got %0d want 3", fetch_count); else n_pass++;
    n_checks++; if (dut_vec !== 7'b0110000) $display("FAIL bp_vec_after: got %b want 0110000", dut_vec); else n_pass++;
  endtask

  task automatic test_halt();
    int c;
    for (int i = 0; i < 20 && !MAR_rd_wr; i++) tick();
    n_checks++; if (MAR_rd_wr !== 1'b1) $display("FAIL halt_wait_mar: got %b want 1", MAR_rd_wr); else n_pass++;
    halt = 1'b1;
    tick();
    halt = 1'b0;
    for (int i = 0; i < 20 && !fetch_valid; i++) tick();
    n_checks++; if (fetch_valid !== 1'b1) $display("FAIL halt_wait_valid: got %b want 1", fetch_valid); else n_pass++;
    c = m_cnt;
    tick();
    n_checks++; if (fetch_count !== 8'(c + 1)) $display("FAIL halt_cnt: got %0d want %0d", fetch_count, c + 1); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (dut_vec !== 7'b0) $display("FAIL halt_idle: got %b want 0", dut_vec); else n_pass++;
      tick();
    end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_addr = AW'(31);
    tick();
    redirect_valid = 1'b0;
    n_checks++; if (pc_addr !== AW'(31)) $display("FAIL idle_redirect_pc: got %0d want 31", pc_addr); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL idle_redirect_busy: got %b want 0", busy); else n_pass++;
    start = 1'b1; fetch_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20 && !fetch_valid; i++) tick();
    n_checks++; if (pc_addr !== AW'(31)) $display("FAIL wrap_pre: got %0d want 31", pc_addr); else n_pass++;
    tick();
    n_checks++; if (pc_addr !== AW'(0)) $display("FAIL wrap_pc: got %0d want 0", pc_addr); else n_pass++;
  endtask

  task automatic test_redirect_pm();
    int c;
    for (int i = 0; i < 20 && !PM_rd_wr; i++) tick();
    n_checks++; if (PM_rd_wr !== 1'b1) $display("FAIL redir_wait_pm: got %b want 1", PM_rd_wr); else n_pass++;
    c = m_cnt;
    redirect_valid = 1'b1; redirect_addr = AW'(12);
    tick();
    redirect_valid = 1'b0;
    n_checks++; if (dut_vec !== 7'b0110000) $display("FAIL redir_pm_vec: got %b want 0110000", dut_vec); else n_pass++;
    n_checks++; if (pc_addr !== AW'(12)) $display("FAIL redir_pm_pc: got %0d want 12", pc_addr); else n_pass++;
    n_checks++; if (fetch_count !== 8'(c)) $display("FAIL redir_pm_cnt: got %0d want %0d", fetch_count, c); else n_pass++;
  endtask

  task automatic test_redirect_hs();
    int c;
    for (int i = 0; i < 20 && !fetch_valid; i++) tick();
    n_checks++; if (fetch_valid !== 1'b1) $display("FAIL redir_hs_wait: got %b want 1", fetch_valid); else n_pass++;
    c = m_cnt;
    redirect_valid = 1'b1; redirect_addr = AW'(7); fetch_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    n_checks++; if (fetch_count !== 8'(c + 1)) $display("FAIL redir_hs_cnt: got %0d want %0d", fetch_count, c + 1); else n_pass++;
    n_checks++; if (pc_addr !== AW'(7)) $display("FAIL redir_hs_pc: got %0d want 7", pc_addr); else n_pass++;
    n_checks++; if (dut_vec !== 7'b0110000) $display("FAIL redir_hs_vec: got %b want 0110000", dut_vec); else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      start          = ($urandom_range(0, 3) == 0);
      halt           = ($urandom_range(0, 15) == 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_addr  = AW'($urandom);
      fetch_ready    = ($urandom_range(0, 3) != 0);
      tick();
      n_checks++; if (dut_vec !== exp_vec()) $display("FAIL rand_vec @%0d: got %b want %b", i, dut_vec, exp_vec()); else n_pass++;
      n_checks++; if (pc_addr !== AW'(m_pc)) $display("FAIL rand_pc @%0d: got %0d want %0d", i, pc_addr, m_pc); else n_pass++;
      n_checks++; if (fetch_count !== 8'(m_cnt)) $display("FAIL rand_cnt @%0d: got %0d want %0d", i, fetch_count, m_cnt); else n_pass++;
    end
    halt = 1'b0; redirect_valid = 1'b0;
  endtask

  task automatic test_saturate();
    int extra;
    extra = 0;
    start = 1'b1; fetch_ready = 1'b1;
    for (int i = 0; i < 3000 && extra < 60; i++) begin
      tick();
      if (m_cnt == 255) extra++;
      n_checks++; if (fetch_count !== 8'(m_cnt)) $display("FAIL sat_cnt: got %0d want %0d", fetch_count, m_cnt); else n_pass++;
    end
    n_checks++; if (fetch_count !== 8'd255) $display("FAIL sat_final: got %0d want 255", fetch_count); else n_pass++;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 20 && !MAR_rd_wr; i++) tick();
    n_checks++; if (MAR_rd_wr !== 1'b1) $display("FAIL arst_wait_mar: got %b want 1", MAR_rd_wr); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (dut_vec !== 7'b0) $display("FAIL arst_vec: got %b want 0", dut_vec); else n_pass++;
    n_checks++; if (pc_addr !== '0) $display("FAIL arst_pc: got %0d want 0", pc_addr); else n_pass++;
    n_checks++; if (fetch_count !== 8'd0) $display("FAIL arst_cnt: got %0d want 0", fetch_count); else n_pass++;
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    tick();
    n_checks++; if (dut_vec !== 7'b0) $display("FAIL arst_after: got %b want 0", dut_vec); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_halt();
    test_wrap();
    test_redirect_pm();
    test_redirect_hs();
    test_random();
    test_saturate();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
